// File: rtl/qam16_pkg.sv
// rtl/qam16_pkg.sv - shared 16-QAM constellation definition for mapper and demapper
package qam16_pkg;

    // Sample width (signed 1s17) used by both ends of the link
    localparam int QAM_WIDTH = 18;

    // Gray bit pairs per axis, ordered from most negative to most positive level
    localparam logic [1:0] GRAY_NEG3 = 2'b00;
    localparam logic [1:0] GRAY_NEG1 = 2'b01;
    localparam logic [1:0] GRAY_POS1 = 2'b11;
    localparam logic [1:0] GRAY_POS3 = 2'b10;

    // Ideal constellation levels, A = 0.25 full scale
    localparam int LEVEL_NEG3 = -98304;
    localparam int LEVEL_NEG1 = -32768;
    localparam int LEVEL_POS1 = 32768;
    localparam int LEVEL_POS3 = 98304;

    // Reference level (2A) assumed before acquisition completes
    localparam int QAM_REF_INIT = 65536;

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } demap_state_t;

endpackage

// File: rtl/qam16_axis_slicer.sv
// rtl/qam16_axis_slicer.sv - one-axis 4-level slicer with saturated decision error
module qam16_axis_slicer
    import qam16_pkg::*;
#(
    parameter int WIDTH = QAM_WIDTH
)(
    input  logic signed [WIDTH-1:0] sample,
    input  logic signed [WIDTH-1:0] thresh,
    output logic        [1:0]       bits,
    output logic signed [WIDTH-1:0] err
);

    // Two guard bits keep x - (+/-3A) exact before saturation
    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = -SAT_MAX - EW'(1);

    logic signed [EW-1:0] x_ext;
    logic signed [EW-1:0] t_ext;
    logic signed [EW-1:0] a_lvl;
    logic signed [EW-1:0] a3_lvl;
    logic signed [EW-1:0] level;
    logic signed [EW-1:0] diff;

    // Threshold compare against +/-T and 0, then error against the chosen level
    always_comb begin
        x_ext  = {{2{sample[WIDTH-1]}}, sample};
        t_ext  = {{2{thresh[WIDTH-1]}}, thresh};
        a_lvl  = t_ext >>> 1;
        a3_lvl = t_ext + a_lvl;
        bits   = GRAY_NEG3;
        level  = -a3_lvl;
        if (x_ext < -t_ext) begin
            bits  = GRAY_NEG3;
            level = -a3_lvl;
        end else if (x_ext[EW-1]) begin
            bits  = GRAY_NEG1;
            level = -a_lvl;
        end else if (x_ext < t_ext) begin
            bits  = GRAY_POS1;
            level = a_lvl;
        end else begin
            bits  = GRAY_POS3;
            level = a3_lvl;
        end
        diff = x_ext - level;
        if (diff > SAT_MAX) begin
            err = SAT_MAX[WIDTH-1:0];
        end else if (diff < SAT_MIN) begin
            err = SAT_MIN[WIDTH-1:0];
        end else begin
            err = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/demapper_16_qam.sv
// rtl/demapper_16_qam.sv - 16-QAM demapper with self-estimated reference level
module demapper_16_qam
    import qam16_pkg::*;
#(
    parameter int WIDTH      = QAM_WIDTH,
    parameter int LEAK_SHIFT = 6,
    parameter int ACQ_LOG2   = 6,
    parameter int REF_INIT   = QAM_REF_INIT
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sym_en,
    input  logic signed [WIDTH-1:0] in_phs_sig,
    input  logic signed [WIDTH-1:0] quad_sig,
    input  logic                    ref_freeze,
    output logic        [3:0]       data,
    output logic                    data_valid,
    output logic signed [WIDTH-1:0] err_in_phs,
    output logic signed [WIDTH-1:0] err_quad,
    output logic signed [WIDTH-1:0] ref_level,
    output logic                    locked
);

    localparam int AW = WIDTH + ACQ_LOG2 + 1;
    localparam int TW = WIDTH + 2;
    localparam logic signed [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [TW-1:0]    REF_MIN = TW'(1);
    localparam logic signed [TW-1:0]    REF_MAX = TW'((2 ** (WIDTH - 1)) - 1);

    demap_state_t state;
    demap_state_t state_next;

    logic [WIDTH-1:0]        abs_i_now;
    logic [WIDTH-1:0]        abs_q_now;
    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_i;
    logic signed [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0]        s1_abs_i;
    logic [WIDTH-1:0]        s1_abs_q;

    logic [WIDTH:0]          mag_sum;
    logic [AW-1:0]           acc;
    logic [AW-1:0]           acc_total;
    logic [ACQ_LOG2-1:0]     acq_count;
    logic                    update_en;
    logic                    acq_last;
    logic signed [TW-1:0]    m_ext;
    logic signed [TW-1:0]    ref_ext;
    logic signed [TW-1:0]    trk_diff;
    logic signed [TW-1:0]    trk_next;
    logic signed [WIDTH-1:0] trk_ref;

    logic [1:0]              bits_i;
    logic [1:0]              bits_q;
    logic signed [WIDTH-1:0] slc_err_i;
    logic signed [WIDTH-1:0] slc_err_q;

    // Saturating magnitude so the most negative sample does not wrap
    always_comb begin
        abs_i_now = in_phs_sig;
        abs_q_now = quad_sig;
        if (in_phs_sig == S_MIN) begin
            abs_i_now = S_MAX;
        end else if (in_phs_sig[WIDTH-1]) begin
            abs_i_now = -in_phs_sig;
        end
        if (quad_sig == S_MIN) begin
            abs_q_now = S_MAX;
        end else if (quad_sig[WIDTH-1]) begin
            abs_q_now = -quad_sig;
        end
    end

    // Stage 1: capture the strobed sample and its magnitudes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_abs_i <= '0;
            s1_abs_q <= '0;
        end else begin
            s1_valid <= sym_en;
            if (sym_en) begin
                s1_i     <= in_phs_sig;
                s1_q     <= quad_sig;
                s1_abs_i <= abs_i_now;
                s1_abs_q <= abs_q_now;
            end
        end
    end

    // Reference estimator datapath: block sum for acquisition, leaky step for tracking
    always_comb begin
        mag_sum   = {1'b0, s1_abs_i} + {1'b0, s1_abs_q};
        acc_total = acc + AW'(mag_sum);
        update_en = s1_valid && !ref_freeze;
        acq_last  = (acq_count == {ACQ_LOG2{1'b1}});
        m_ext     = {2'b00, mag_sum[WIDTH:1]};
        ref_ext   = {{2{ref_level[WIDTH-1]}}, ref_level};
        trk_diff  = m_ext - ref_ext;
        trk_next  = ref_ext + (trk_diff >>> LEAK_SHIFT);
        if (trk_next < REF_MIN) begin
            trk_ref = REF_MIN[WIDTH-1:0];
        end else if (trk_next > REF_MAX) begin
            trk_ref = REF_MAX[WIDTH-1:0];
        end else begin
            trk_ref = trk_next[WIDTH-1:0];
        end
    end

    // Estimator state: accumulator, acquisition counter and reference level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            acq_count <= '0;
            ref_level <= WIDTH'(REF_INIT);
        end else if (update_en) begin
            if (state == ST_ACQUIRE) begin
                acc       <= acc_total;
                acq_count <= acq_count + 1'b1;
                if (acq_last) begin
                    ref_level <= acc_total[ACQ_LOG2+1 +: WIDTH];
                end
            end else begin
                ref_level <= trk_ref;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_ACQUIRE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: leave acquisition on the last block symbol; track is sticky
    always_comb begin
        state_next = state;
        if (state == ST_ACQUIRE && update_en && acq_last) begin
            state_next = ST_TRACK;
        end
    end

    // FSM outputs
    always_comb begin
        locked = (state == ST_TRACK);
    end

    qam16_axis_slicer #(.WIDTH(WIDTH)) u_slicer_i (
        .sample (s1_i),
        .thresh (ref_level),
        .bits   (bits_i),
        .err    (slc_err_i)
    );

    qam16_axis_slicer #(.WIDTH(WIDTH)) u_slicer_q (
        .sample (s1_q),
        .thresh (ref_level),
        .bits   (bits_q),
        .err    (slc_err_q)
    );

    // Stage 2: register decisions; only symbols sliced while locked are flagged valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data       <= '0;
            data_valid <= 1'b0;
            err_in_phs <= '0;
            err_quad   <= '0;
        end else begin
            data_valid <= s1_valid && (state == ST_TRACK);
            if (s1_valid) begin
                data       <= {bits_q, bits_i};
                err_in_phs <= slc_err_i;
                err_quad   <= slc_err_q;
            end
        end
    end

endmodule

// File: tb/tb_demapper_16_qam.sv
// tb/tb_demapper_16_qam.sv - self-checking bench for demapper_16_qam
module tb_demapper_16_qam;

    localparam int W = 18;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                sym_en;
    logic signed [W-1:0] in_phs_sig;
    logic signed [W-1:0] quad_sig;
    logic                ref_freeze;
    logic [3:0]          data;
    logic                data_valid;
    logic signed [W-1:0] err_in_phs;
    logic signed [W-1:0] err_quad;
    logic signed [W-1:0] ref_level;
    logic                locked;

    demapper_16_qam #(
        .WIDTH(18), .LEAK_SHIFT(6), .ACQ_LOG2(6), .REF_INIT(65536)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sym_en     (sym_en),
        .in_phs_sig (in_phs_sig),
        .quad_sig   (quad_sig),
        .ref_freeze (ref_freeze),
        .data       (data),
        .data_valid (data_valid),
        .err_in_phs (err_in_phs),
        .err_quad   (err_quad),
        .ref_level  (ref_level),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int first_valid = -1;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   due;
        int   data;
        int   ei;
        int   eq;
        int   valid;
        int   refv;
        int   sent;
    } exp_t;

    exp_t expq[$];

    // Behavioural model state
    int  m_ref;
    int  m_acc;
    int  m_cnt;
    bit  m_locked;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic int mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 131071) ? 131071 : a;
    endfunction

    // Which of the four levels a value falls in: 0:-3A 1:-A 2:+A 3:+3A
    function automatic int region(input int x, input int t);
        if (x < -t) return 0;
        if (x < 0)  return 1;
        if (x < t)  return 2;
        return 3;
    endfunction

    function automatic int gray(input int idx);
        int g[4] = '{0, 1, 3, 2};
        return g[idx];
    endfunction

    function automatic int level_of(input int idx, input int t);
        int a;
        int lv[4];
        a  = t / 2;
        lv = '{-(t + a), -a, a, t + a};
        return lv[idx];
    endfunction

    task automatic model_reset();
        m_ref    = 65536;
        m_acc    = 0;
        m_cnt    = 0;
        m_locked = 0;
        expq.delete();
    endtask

    // Predict outputs for one symbol, then advance the reference estimate
    task automatic model_push(input int i, input int q, input int due, input int sent);
        exp_t e;
        int ri, rq, s, m;
        ri      = region(i, m_ref);
        rq      = region(q, m_ref);
        e.due   = due;
        e.data  = gray(rq) * 4 + gray(ri);
        e.ei    = sat(i - level_of(ri, m_ref));
        e.eq    = sat(q - level_of(rq, m_ref));
        e.valid = m_locked ? 1 : 0;
        e.sent  = sent;
        if (!ref_freeze) begin
            s = mag(i) + mag(q);
            if (!m_locked) begin
                m_acc += s;
                m_cnt++;
                if (m_cnt == 64) begin
                    m_ref    = m_acc / 128;
                    m_locked = 1;
                end
            end else begin
                m = s / 2;
                m_ref = m_ref + ((m - m_ref) >>> 6);
                if (m_ref < 1) m_ref = 1;
                if (m_ref > 131071) m_ref = 131071;
            end
        end
        e.refv = m_ref;
        expq.push_back(e);
    endtask

    task automatic send(input int i, input int q, input int sent);
        @(posedge clk);
        #1;
        sym_en     = 1'b1;
        in_phs_sig = W'(i);
        quad_sig   = W'(q);
        model_push(i, q, cyc + 2, sent);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sym_en = 1'b0;
        end
    endtask

    // Compare process: every cycle out of reset, against the model queue
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                exp_t e;
                e = expq.pop_front();
                check("data_valid", data_valid, e.valid);
                check("data", data, e.data);
                check("err_in_phs", err_in_phs, e.ei);
                check("err_quad", err_quad, e.eq);
                check("ref_level", ref_level, e.refv);
                if (e.sent >= 0) check("decision", data, e.sent);
                if (data_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            end else begin
                check("idle_valid", data_valid, 0);
            end
        end
    end

    int lv_full[4] = '{-98304, -32768, 32768, 98304};
    int lv_half[4] = '{-49152, -16384, 16384, 49152};

    initial begin
        int c65;
        int frozen_ref;
        int d;
        int ii, qi;
        reset_n    = 1'b0;
        sym_en     = 1'b0;
        in_phs_sig = '0;
        quad_sig   = '0;
        ref_freeze = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst_data", data, 0);
        check("rst_valid", data_valid, 0);
        check("rst_err_i", err_in_phs, 0);
        check("rst_err_q", err_quad, 0);
        check("rst_ref", ref_level, 65536);
        check("rst_locked", locked, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1: acquisition over 64 ideal symbols cycling all 16 points
        for (int k = 0; k < 64; k++) begin
            send(lv_full[k % 4], lv_full[(k / 4) % 4], -1);
        end
        idle(3);
        check("acq_locked", locked, 1);
        check("acq_ref", ref_level, 65536);

        // 2: locked symbol, latency 2
        send(98304, -32768, -1);
        idle(2);
        @(negedge clk);
        check("t2_data", data, 4'b0110);
        check("t2_valid", data_valid, 1);
        check("t2_err_i", err_in_phs, 0);
        check("t2_err_q", err_quad, 0);
        idle(2);

        // 3 and 4 with the reference held at 65536
        ref_freeze = 1'b1;
        send(0, 65536, -1);
        idle(2);
        @(negedge clk);
        check("t3_data", data, 4'b1011);
        check("t3_err_i", err_in_phs, -32768);
        check("t3_err_q", err_quad, -32768);
        idle(1);
        send(-131072, 131071, -1);
        idle(2);
        @(negedge clk);
        check("t4_data", data, 4'b1000);
        check("t4_err_i", err_in_phs, -32768);
        check("t4_err_q", err_quad, 32767);
        check("t4_ref_held", ref_level, 65536);
        idle(2);
        ref_freeze = 1'b0;

        // 5: halved amplitude, magnitude classes interleaved so the average stays at 2A
        for (int k = 0; k < 1000; k++) begin
            case (k % 4)
                0: begin ii = 2; qi = 2; end
                1: begin ii = 3; qi = 3; end
                2: begin ii = 2; qi = 3; end
                default: begin ii = 3; qi = 2; end
            endcase
            if ((k / 4) % 2 == 1) ii = 3 - ii;
            if ((k / 8) % 2 == 1) qi = 3 - qi;
            send(lv_half[ii], lv_half[qi], (k >= 500) ? gray(qi) * 4 + gray(ii) : -1);
        end
        idle(3);
        d = ref_level - 32768;
        if (d < 0) d = -d;
        check("t5_ref_within_1pct", (d <= 327) ? 1 : 0, 1);

        frozen_ref = m_ref;
        ref_freeze = 1'b1;
        for (int k = 0; k < 100; k++) begin
            send(lv_full[(k * 3) % 4], lv_full[k % 4], -1);
        end
        idle(3);
        check("t5_ref_frozen", ref_level, frozen_ref);
        ref_freeze = 1'b0;

        // 6: reset pulsed during back-to-back symbols
        for (int k = 0; k < 20; k++) begin
            send(lv_full[k % 4], lv_full[(k / 4) % 4], -1);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t6_data", data, 0);
        check("t6_valid", data_valid, 0);
        check("t6_err_i", err_in_phs, 0);
        check("t6_err_q", err_quad, 0);
        check("t6_ref", ref_level, 65536);
        check("t6_locked", locked, 0);
        @(posedge clk);
        #1;
        in_phs_sig = W'(-98304);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sym_en  = 1'b0;
        first_valid = -1;
        c65 = -1;
        for (int k = 0; k < 70; k++) begin
            send(lv_full[(k + 1) % 4], lv_full[(k / 4) % 4], -1);
            if (k == 64) c65 = cyc;
        end
        idle(3);
        check("t6_relocked", locked, 1);
        check("t6_first_valid_cycle", first_valid, c65 + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
